// File: rtl/mem_io_responder.sv
// Responder side of the CPU byte bus: 1-cycle byte RAM in the low space plus the 0x3xxxx I/O
// window (UART TX FIFO with back-pressure, RX handshake, cycle counter, program stop).
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_W  = 17,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned FULL_MARGIN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);

    localparam int unsigned PtrW = $clog2(TX_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthLevel = CntW'(TX_DEPTH);
    localparam logic [CntW-1:0] FullLevel  = CntW'(TX_DEPTH - FULL_MARGIN);

    logic                  io;
    logic [2:0]            io_off;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  rd_ram, rd_io, wr_io;
    logic                  unused_addr;

    assign io          = (mem_a[17:16] == 2'b11);
    assign io_off      = mem_a[2:0];
    assign ram_idx     = mem_a[RAM_ADDR_W-1:0];
    assign rd_ram      = !mem_wr && !io;
    assign rd_io       = !mem_wr && io;
    assign wr_io       = mem_wr && io;
    assign unused_addr = ^mem_a[31:18];

    // Byte RAM, kept free of reset so it maps onto block memory.
    logic [7:0] ram [2**RAM_ADDR_W];
    logic [7:0] ram_rd_q;

    always_ff @(posedge clk_in) begin
        if (mem_wr && !io) begin
            ram[ram_idx] <= mem_dout;
        end
        if (rd_ram) begin
            ram_rd_q <= ram[ram_idx];
        end
    end

    // State registers
    logic            sel_ram_q, sel_ram_d;
    logic [7:0]      io_rd_q, io_rd_d;
    logic [31:0]     cycle_q, cycle_d;
    logic [31:0]     snapshot_q, snapshot_d;
    logic            stop_q, stop_d;
    logic            overflow_q, overflow_d;
    logic            buf_full_q, buf_full_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [7:0] fifo_mem [TX_DEPTH];
    logic       push, pop, do_push, fifo_full;
    logic [7:0] push_byte;

    always_comb begin
        sel_ram_d  = rd_ram;
        io_rd_d    = 8'h00;
        snapshot_d = snapshot_q;
        rx_ready   = 1'b0;
        if (rd_io) begin
            case (io_off)
                3'd0: begin
                    if (rx_valid) begin
                        io_rd_d  = rx_byte;
                        rx_ready = !rst_in;
                    end
                end
                3'd4: begin
                    snapshot_d = cycle_q;
                    io_rd_d    = cycle_q[7:0];
                end
                3'd5:    io_rd_d = snapshot_q[15:8];
                3'd6:    io_rd_d = snapshot_q[23:16];
                3'd7:    io_rd_d = snapshot_q[31:24];
                default: io_rd_d = 8'h00;
            endcase
        end
    end

    assign mem_din = sel_ram_q ? ram_rd_q : io_rd_q;

    always_comb begin
        push      = wr_io && ((io_off == 3'd0 && mem_dout != 8'h00) || io_off == 3'd4);
        push_byte = (io_off == 3'd4) ? 8'h00 : mem_dout;
        fifo_full = (count_q == DepthLevel);
        pop       = tx_valid && tx_ready;
        // A pop frees the slot the same cycle, so push-at-full with pop still lands.
        do_push   = push && (!fifo_full || pop);

        overflow_d = overflow_q || (push && fifo_full && !pop);
        stop_d     = stop_q || (wr_io && io_off == 3'd4);
        cycle_d    = cycle_q + 32'd1;

        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        buf_full_d = (count_d >= FullLevel);
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= push_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_ram_q  <= 1'b0;
            io_rd_q    <= 8'h00;
            cycle_q    <= 32'd0;
            snapshot_q <= 32'd0;
            stop_q     <= 1'b0;
            overflow_q <= 1'b0;
            buf_full_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            sel_ram_q  <= sel_ram_d;
            io_rd_q    <= io_rd_d;
            cycle_q    <= cycle_d;
            snapshot_q <= snapshot_d;
            stop_q     <= stop_d;
            overflow_q <= overflow_d;
            buf_full_q <= buf_full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign tx_valid       = (count_q != '0);
    assign tx_byte        = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
    assign io_buffer_full = buf_full_q;
    assign prog_stop      = stop_q;
    assign tx_overflow    = overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus randomized traffic, all checked every
// cycle against a queue/array model of the bus responder.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_stop;
    logic        tx_overflow;

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_wr        (mem_wr),
        .mem_din       (mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .prog_stop     (prog_stop),
        .tx_overflow   (tx_overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO as a queue, RAM as a sparse array, counter as an integer.
    byte unsigned q_m[$];
    logic [7:0]   ram_m [int];
    logic [31:0]  cnt_m, snap_m;
    logic [7:0]   din_m;
    bit           stop_m, ovf_m, full_m, din_chk, model_ok = 0;

    always @(posedge clk_in) begin : model
        bit         io_m, push_m, pop_m;
        logic [2:0] off_m;
        if (rst_in) begin
            q_m.delete();
            cnt_m = 0; snap_m = 0; din_m = 0;
            stop_m = 0; ovf_m = 0; full_m = 0;
            din_chk = 1; model_ok = 1;
        end else begin
            io_m    = (mem_a[17:16] == 2'b11);
            off_m   = mem_a[2:0];
            din_chk = 1;
            if (mem_wr) begin
                din_chk = 0;
                if (!io_m) ram_m[int'(mem_a[16:0])] = mem_dout;
            end else if (!io_m) begin
                if (ram_m.exists(int'(mem_a[16:0]))) din_m = ram_m[int'(mem_a[16:0])];
                else din_chk = 0;
            end else begin
                case (off_m)
                    3'd0: din_m = rx_valid ? rx_byte : 8'h00;
                    3'd4: begin din_m = cnt_m[7:0]; snap_m = cnt_m; end
                    3'd5: din_m = snap_m[15:8];
                    3'd6: din_m = snap_m[23:16];
                    3'd7: din_m = snap_m[31:24];
                    default: din_m = 8'h00;
                endcase
            end
            push_m = mem_wr && io_m && ((off_m == 0 && mem_dout != 0) || off_m == 4);
            if (mem_wr && io_m && off_m == 4) stop_m = 1;
            pop_m = (q_m.size() != 0) && tx_ready;
            if (pop_m) void'(q_m.pop_front());
            if (push_m) begin
                if (q_m.size() == 16) ovf_m = 1;
                else q_m.push_back((off_m == 4) ? 8'h00 : mem_dout);
            end
            full_m = (q_m.size() >= 12);
            cnt_m  = cnt_m + 1;
        end
    end

    always @(negedge clk_in) begin
        if (model_ok) begin
            chk("tx_valid", tx_valid, q_m.size() != 0);
            chk("tx_byte", tx_byte, (q_m.size() != 0) ? q_m[0] : 8'h00);
            chk("io_buffer_full", io_buffer_full, full_m);
            chk("prog_stop", prog_stop, stop_m);
            chk("tx_overflow", tx_overflow, ovf_m);
            if (din_chk) chk("mem_din", mem_din, din_m);
            chk("rx_ready", rx_ready, !rst_in && !mem_wr && mem_a[17:16] == 2'b11
                && mem_a[2:0] == 3'd0 && rx_valid);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_bus(input bit wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr = wr; mem_a = a; mem_dout = d;
    endtask

    task automatic do_reset();
        set_bus(0, 32'h0, 8'h0);
        rst_in = 1;
        tick();
        rst_in = 0;
    endtask

    initial begin : stim
        logic [31:0] a;
        logic [7:0]  b0, b1, b2, b3;
        rst_in = 1; tx_ready = 0; rx_valid = 0; rx_byte = 0;
        set_bus(0, 32'h0, 8'h0);
        tick(); tick();
        chk("reset mem_din", mem_din, 8'h00);
        chk("reset tx_valid", tx_valid, 1'b0);
        chk("reset tx_byte", tx_byte, 8'h00);
        chk("reset io_buffer_full", io_buffer_full, 1'b0);
        chk("reset prog_stop", prog_stop, 1'b0);
        chk("reset tx_overflow", tx_overflow, 1'b0);
        chk("reset rx_ready", rx_ready, 1'b0);
        rst_in = 0;

        // RAM write then read next cycle; upper/bit-17 aliasing
        set_bus(1, 32'h0000_0010, 8'hA5); tick();
        set_bus(0, 32'h0000_0010, 8'h00); tick();
        chk("ram readback", mem_din, 8'hA5);
        set_bus(0, 32'h8002_0010, 8'h00); tick();
        chk("ram alias readback", mem_din, 8'hA5);

        // TX pushes, zero byte ignored
        set_bus(1, 32'h0003_0000, 8'h41); tick();
        set_bus(1, 32'h0003_0000, 8'h00); tick();
        set_bus(1, 32'h0003_0000, 8'h42); tick();
        set_bus(0, 32'h0, 8'h0);
        chk("tx head first", tx_byte, 8'h41);
        tx_ready = 1; tick();
        chk("tx head second", tx_byte, 8'h42);
        tick();
        chk("tx drained", tx_valid, 1'b0);
        tx_ready = 0;

        // Fill to threshold and overflow
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            set_bus(1, 32'h0003_0000, 8'(i)); tick();
            chk("fill io_buffer_full", io_buffer_full, i >= 12);
            chk("fill tx_overflow", tx_overflow, i >= 17);
        end
        set_bus(0, 32'h0, 8'h0);
        tx_ready = 1;
        for (int k = 1; k <= 16; k++) begin
            chk("drain order", tx_byte, 8'(k));
            tick();
        end
        chk("drain empty", tx_valid, 1'b0);
        chk("overflow sticky", tx_overflow, 1'b1);
        tx_ready = 0;

        // Cycle counter snapshot
        do_reset();
        repeat (100) tick();
        set_bus(0, 32'h0003_0004, 8'h0); tick(); b0 = mem_din;
        set_bus(0, 32'h0003_0005, 8'h0); tick(); b1 = mem_din;
        set_bus(0, 32'h0003_0006, 8'h0); tick(); b2 = mem_din;
        set_bus(0, 32'h0003_0007, 8'h0); tick(); b3 = mem_din;
        chk("snapshot value", {b3, b2, b1, b0}, 32'd100);

        // RX handshake
        rx_valid = 1; rx_byte = 8'h37;
        set_bus(0, 32'h0003_0000, 8'h0); #1;
        chk("rx_ready pulse", rx_ready, 1'b1);
        tick();
        chk("rx data", mem_din, 8'h37);
        rx_valid = 0; #1;
        chk("rx_ready idle", rx_ready, 1'b0);
        tick();
        chk("rx empty data", mem_din, 8'h00);

        // Program stop, then reset with FIFO non-empty
        set_bus(1, 32'h0003_0004, 8'h99); tick();
        set_bus(0, 32'h0, 8'h0);
        chk("prog_stop set", prog_stop, 1'b1);
        chk("stop pushes byte", tx_valid, 1'b1);
        chk("stop byte zero", tx_byte, 8'h00);
        rst_in = 1; tick();
        chk("rst tx_valid", tx_valid, 1'b0);
        chk("rst prog_stop", prog_stop, 1'b0);
        chk("rst mem_din", mem_din, 8'h00);
        rst_in = 0;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_in = ($urandom_range(0, 199) == 0);
            if (rst_in) begin
                set_bus(0, 32'h0, 8'h0);
            end else begin
                a = $urandom;
                if ($urandom_range(0, 9) < 3) begin
                    a[17:16] = 2'b11;
                end else begin
                    a[16:5] = '0;
                    if (a[17:16] == 2'b11) a[17] = 1'b0;
                end
                set_bus(1'($urandom_range(0, 1)), a,
                        ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            end
            tx_ready = (n < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rx_valid = 1'($urandom_range(0, 1));
            rx_byte  = 8'($urandom);
            tick();
        end
        rst_in = 0;
        set_bus(0, 32'h0, 8'h0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
